// File: rtl/column_span_writer.sv
// Column span rasteriser: takes one vertical span at a time and emits
// one framebuffer pixel write per cycle, then handshakes frame completion.
module column_span_writer #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int COLOR_W  = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               span_valid,
  output logic               span_ready,
  input  logic [8:0]         span_x,
  input  logic [7:0]         span_ytop,
  input  logic [7:0]         span_ybot,
  input  logic [COLOR_W-1:0] span_color,
  input  logic               span_last,
  output logic [16:0]        coords_out,
  output logic [COLOR_W-1:0] color_out,
  output logic               framebuffer_we,
  output logic               render_done,
  input  logic               render_ack,
  output logic [16:0]        pixel_count
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_e;

  localparam logic [7:0]  YMAX    = 8'(SCREEN_H - 1);
  localparam logic [16:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [16:0]        coords_q, coords_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [7:0]         ybot_q, ybot_d;
  logic               last_q, last_d;
  logic               we_q, we_d;
  logic [16:0]        cnt_q, cnt_d;

  logic [7:0] ybot_c;
  logic       empty;

  assign ybot_c = (span_ybot > YMAX) ? YMAX : span_ybot;
  assign empty  = (32'(span_x) >= 32'(SCREEN_W)) || (ybot_c < span_ytop);

  always_comb begin
    state_d  = state_q;
    coords_d = coords_q;
    color_d  = color_q;
    ybot_d   = ybot_q;
    last_d   = last_q;
    we_d     = 1'b0;
    cnt_d    = cnt_q;
    if (we_q && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 17'd1;
    unique case (state_q)
      IDLE: begin
        if (span_valid) begin
          ybot_d = ybot_c;
          last_d = span_last;
          if (empty) begin
            state_d = span_last ? DONE : IDLE;
          end else begin
            coords_d = {span_x, span_ytop};
            color_d  = span_color;
            we_d     = 1'b1;
            state_d  = FILL;
          end
        end
      end
      FILL: begin
        // coords_q holds the pixel being written this cycle
        if (coords_q[7:0] == ybot_q) begin
          state_d = last_q ? DONE : IDLE;
        end else begin
          coords_d[7:0] = coords_q[7:0] + 8'd1;
          we_d          = 1'b1;
        end
      end
      DONE: begin
        if (render_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      coords_q <= '0;
      color_q  <= '0;
      ybot_q   <= '0;
      last_q   <= 1'b0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      coords_q <= coords_d;
      color_q  <= color_d;
      ybot_q   <= ybot_d;
      last_q   <= last_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
    end
  end

  assign span_ready     = (state_q == IDLE) && !Reset;
  assign render_done    = (state_q == DONE);
  assign framebuffer_we = we_q;
  assign coords_out     = coords_q;
  assign color_out      = color_q;
  assign pixel_count    = cnt_q;

endmodule

// File: tb/tb_column_span_writer.sv
// Randomised span stimulus checked every cycle against a schedule-based
// model of expected writes, readiness, frame-done and pixel count.
module tb_column_span_writer;
  localparam int W = 320;
  localparam int H = 240;
  localparam int CW = 8;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          span_valid;
  logic          span_ready;
  logic [8:0]    span_x;
  logic [7:0]    span_ytop;
  logic [7:0]    span_ybot;
  logic [CW-1:0] span_color;
  logic          span_last;
  logic [16:0]   coords_out;
  logic [CW-1:0] color_out;
  logic          framebuffer_we;
  logic          render_done;
  logic          render_ack;
  logic [16:0]   pixel_count;

  column_span_writer #(.SCREEN_W(W), .SCREEN_H(H), .COLOR_W(CW)) dut (
    .Clk(Clk), .Reset(Reset),
    .span_valid(span_valid), .span_ready(span_ready),
    .span_x(span_x), .span_ytop(span_ytop), .span_ybot(span_ybot),
    .span_color(span_color), .span_last(span_last),
    .coords_out(coords_out), .color_out(color_out),
    .framebuffer_we(framebuffer_we),
    .render_done(render_done), .render_ack(render_ack),
    .pixel_count(pixel_count)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [16:0]   exp_coord[int];
  logic [CW-1:0] exp_col[int];
  int            busy_end = -1;
  int            done_start = -1;
  bit            in_done = 1'b0;
  int            pc_m = 0;
  bit            chk_en = 1'b0;
  logic [16:0]   log_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    bit wr;
    forever begin
      @(negedge Clk);
      if (chk_en && !Reset) begin
        if (cyc == done_start) in_done = 1'b1;
        wr = exp_coord.exists(cyc);
        chk("we", 32'(framebuffer_we), 32'(wr));
        if (wr) begin
          chk("coords", 32'(coords_out), 32'(exp_coord[cyc]));
          chk("color", 32'(color_out), 32'(exp_col[cyc]));
        end
        chk("pixel_count", 32'(pixel_count), 32'(pc_m));
        chk("render_done", 32'(render_done), 32'(in_done));
        chk("span_ready", 32'(span_ready),
            32'((cyc > busy_end) && !in_done));
        if (framebuffer_we) log_q.push_back(coords_out);
        if (wr && pc_m < 131071) pc_m++;
        if (in_done && render_ack) begin
          in_done = 1'b0;
          pc_m = 0;
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after accept.
  task automatic send(input logic [8:0] x, input logic [7:0] t,
                      input logic [7:0] b, input logic [CW-1:0] c,
                      input bit l);
    int acc;
    int len;
    int bc;
    bit got;
    got = 1'b0;
    acc = 0;
    span_x = x;
    span_ytop = t;
    span_ybot = b;
    span_color = c;
    span_last = l;
    span_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      if (span_ready) begin
        got = 1'b1;
        acc = cyc;
        break;
      end
      tick(1);
    end
    chk("accept", 32'(got), 32'd1);
    if (!got) return;
    tick(1);
    bc = (int'(b) > H - 1) ? H - 1 : int'(b);
    len = (int'(x) >= W || bc < int'(t)) ? 0 : bc - int'(t) + 1;
    for (int k = 0; k < len; k++) begin
      exp_coord[acc + 1 + k] = {x, 8'(int'(t) + k)};
      exp_col[acc + 1 + k] = c;
    end
    busy_end = acc + len;
    if (l) done_start = acc + len + 1;
  endtask

  task automatic ack_frame(input int hold);
    int i;
    for (i = 0; i < 600 && !in_done; i++) tick(1);
    chk("done_wait", 32'(in_done), 32'd1);
    tick(hold);
    render_ack = 1'b1;
    tick(1);
    render_ack = 1'b0;
  endtask

  initial begin
    logic [8:0] rx;
    logic [7:0] rt;
    logic [7:0] rb;
    bit         rl;
    fork
      monitor();
    join_none
    Reset = 1'b1;
    span_valid = 1'b0;
    span_x = '0;
    span_ytop = '0;
    span_ybot = '0;
    span_color = '0;
    span_last = 1'b0;
    render_ack = 1'b0;
    tick(3);
    chk("rst_ready", 32'(span_ready), 32'd0);
    chk("rst_we", 32'(framebuffer_we), 32'd0);
    chk("rst_done", 32'(render_done), 32'd0);
    chk("rst_pc", 32'(pixel_count), 32'd0);
    Reset = 1'b0;
    chk_en = 1'b1;
    tick(2);

    log_q.delete();
    send(9'd5, 8'd10, 8'd13, 8'h2A, 1'b0);
    span_valid = 1'b0;
    tick(6);
    chk("t28_n", 32'(log_q.size()), 32'd4);
    chk("t28_first", 32'(log_q[0]), 32'h0050A);
    chk("t28_lastpx", 32'(log_q[3]), 32'h0050D);
    chk("t28_pc", 32'(pixel_count), 32'd4);
    chk("t28_ready", 32'(span_ready), 32'd1);

    log_q.delete();
    send(9'd0, 8'd230, 8'd255, 8'h11, 1'b0);
    span_valid = 1'b0;
    tick(14);
    chk("t29_n", 32'(log_q.size()), 32'd10);
    chk("t29_lastpx", 32'(log_q[9]), 32'h000EF);
    chk("t29_pc", 32'(pixel_count), 32'd14);

    log_q.delete();
    send(9'd320, 8'd0, 8'd5, 8'h77, 1'b1);
    span_valid = 1'b0;
    tick(3);
    chk("t30_done", 32'(render_done), 32'd1);
    chk("t30_nowr", 32'(log_q.size()), 32'd0);
    ack_frame(2);
    chk("t30_pc", 32'(pixel_count), 32'd0);
    chk("t30_idle", 32'(span_ready), 32'd1);

    log_q.delete();
    send(9'd100, 8'd7, 8'd7, 8'h55, 1'b1);
    span_valid = 1'b0;
    render_ack = 1'b1;
    tick(1);
    render_ack = 1'b0;
    chk("t31_done", 32'(render_done), 32'd1);
    chk("t31_n", 32'(log_q.size()), 32'd1);
    chk("t31_px", 32'(log_q[0]), 32'h06407);
    ack_frame(1);

    send(9'd50, 8'd20, 8'd39, 8'h3C, 1'b0);
    span_valid = 1'b0;
    tick(2);
    Reset = 1'b1;
    #1;
    chk("t32_we", 32'(framebuffer_we), 32'd0);
    chk("t32_coords", 32'(coords_out), 32'd0);
    chk("t32_color", 32'(color_out), 32'd0);
    chk("t32_pc", 32'(pixel_count), 32'd0);
    chk("t32_ready", 32'(span_ready), 32'd0);
    exp_coord.delete();
    exp_col.delete();
    busy_end = -1;
    done_start = -1;
    in_done = 1'b0;
    pc_m = 0;
    tick(2);
    Reset = 1'b0;
    log_q.delete();
    tick(6);
    chk("t32_nowr", 32'(log_q.size()), 32'd0);

    log_q.delete();
    send(9'd1, 8'd0, 8'd3, 8'h01, 1'b0);
    send(9'd2, 8'd10, 8'd11, 8'h02, 1'b0);
    send(9'd3, 8'd100, 8'd104, 8'h03, 1'b0);
    span_valid = 1'b0;
    tick(8);
    chk("t33_n", 32'(log_q.size()), 32'd11);
    chk("t33_pc", 32'(pixel_count), 32'd11);

    for (int n = 0; n < 40; n++) begin
      rx = 9'($urandom_range(0, 330));
      rt = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1)
        rb = 8'((int'(rt) + $urandom_range(0, 20) > 255) ? 255
                : int'(rt) + $urandom_range(0, 20));
      else
        rb = 8'($urandom_range(0, 255));
      rl = ($urandom_range(0, 3) == 0);
      send(rx, rt, rb, 8'($urandom), rl);
      if (rl) begin
        span_valid = 1'b0;
        ack_frame($urandom_range(0, 3));
      end else if ($urandom_range(0, 1) == 1) begin
        span_valid = 1'b0;
        tick($urandom_range(0, 4));
      end
    end
    span_valid = 1'b0;
    tick(260);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/column_span_writer.md
COLUMN_SPAN_WRITER -- requirements
Module: column_span_writer

Interface
REQ-001 SHALL have parameter SCREEN_W, default 320, meaning the framebuffer width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 240, meaning the framebuffer height in pixels.
REQ-003 SHALL have parameter COLOR_W, default 8, meaning the palette index width.
REQ-004 SHALL have port Clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have ports span_valid, input, 1 bit, and span_ready, output, 1 bit, forming the span-accept handshake.
REQ-007 SHALL have ports span_x, span_ytop and span_ybot, all inputs, with widths 9, 8 and 8 bits respectively, defining the column and inclusive row range.
REQ-008 SHALL have port span_color, input, COLOR_W bits, the fill color.
REQ-009 SHALL have port span_last, input, 1 bit, marking the final span of a frame.
REQ-010 SHALL have port coords_out, output, 17 bits, holding {x[8:0], y[7:0]} as the framebuffer write address.
REQ-011 SHALL have port color_out, output, COLOR_W bits, the framebuffer write data.
REQ-012 SHALL have port framebuffer_we, output, 1 bit, the write strobe, one pixel per cycle.
REQ-013 SHALL have ports render_done, output, 1 bit, and render_ack, input, 1 bit, forming the frame-complete handshake with the framebuffer.
REQ-014 SHALL have port pixel_count, output, 17 bits, counting pixels written in the current frame.

Function
REQ-015 SHALL implement states IDLE, FILL and DONE.
REQ-016 span_ready SHALL equal 1 only in IDLE; a span is accepted on a cycle with span_valid=1 and span_ready=1.
REQ-017 On accept, the block SHALL latch x, ytop, ybot, color and last, clamping ybot to SCREEN_H-1.
REQ-018 Span with span_x>=SCREEN_W or clamped ybot<ytop is empty: zero writes; next state is DONE if last=1, otherwise IDLE.
REQ-019 Non-empty span accepted at cycle N: state FILL; write y=ytop at N+1, then y+1 each cycle through ybot inclusive, with framebuffer_we=1 on exactly (ybot-ytop+1) cycles.
REQ-020 coords_out and color_out SHALL be registered and valid on every cycle framebuffer_we=1; framebuffer_we=0 in IDLE and DONE.
REQ-021 Cycle after the last pixel: DONE if last=1, otherwise IDLE (span_ready=1 that cycle).
REQ-022 render_done SHALL be 1 in every DONE cycle and 0 otherwise.
REQ-023 In DONE, render_ack=1 SHALL move to IDLE next cycle and clear pixel_count to 0; render_ack outside DONE is ignored.
REQ-024 pixel_count SHALL increment once per write, saturating at 2^17-1.
REQ-025 Row counter SHALL NOT wrap past SCREEN_H-1 due to the clamp; ytop=ybot SHALL produce exactly one write.

Reset
REQ-026 Reset=1 SHALL asynchronously force IDLE, span_ready=0 while asserted, framebuffer_we=0, render_done=0, coords_out=0, color_out=0, pixel_count=0.
REQ-027 Reset mid-FILL SHALL abort the span with no further writes; span_ready=1 first cycle after deassert.

Verification
REQ-028 Span x=5, ytop=10, ybot=13, color=0x2A, last=0 -> writes (5,10)..(5,13) on 4 consecutive cycles, color 0x2A, then span_ready=1, pixel_count=4.
REQ-029 Span x=0, ytop=230, ybot=255 -> clamped to 239; 10 writes, last at (0,239).
REQ-030 Span x=320, last=1 -> zero writes; render_done=1 next cycle, held until render_ack; IDLE one cycle after ack; pixel_count=0.
REQ-031 Span ytop=ybot=7, last=1 -> one write at (x,7); render_done=1 the following cycle; render_ack pulse while FILL ignored.
REQ-032 Reset asserted on 3rd write of a 20-pixel span -> immediate we=0, all outputs 0; no writes after deassert until new span.
REQ-033 Back-to-back spans with span_valid held high -> exactly one idle (no-write) cycle between spans; pixel_count = sum of lengths.
